// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, arbiter FSM encodings and lock-timeout width.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int LOCK_CNT_W  = 16;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE      = 2'd0;
  localparam arb_state_t ST_ISSUE     = 2'd1;
  localparam arb_state_t ST_WAIT_BUSY = 2'd2;
  localparam arb_state_t ST_WAIT_DONE = 2'd3;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr, wrapping modulo N.
module uart_rr_pick
#(
  parameter int N  = 4,
  parameter int IW = 2
)(
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [N-1:0]  hit;
  logic [IW-1:0] cand [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rot
      logic [IW:0] sum;
      // ptr is always below N, so a single conditional subtract gives the modulo
      assign sum       = {1'b0, ptr} + (IW+1)'(gi);
      assign cand[gi]  = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
      assign hit[gi]   = req[cand[gi]];
    end
  endgenerate

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (hit[k]) begin
        valid = 1'b1;
        idx   = cand[k];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter among N byte requesters,
// with a per-message lock and an idle timeout that releases a stalled lock.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int                    N       = 4,
  parameter logic [LOCK_CNT_W-1:0] LOCK_TO = 16'hFFFF,
  localparam int                   OW      = (N > 1) ? $clog2(N) : 1
)(
  input  logic                     uart_clk,
  input  logic                     uart_rst,
  input  logic [N-1:0]             req,
  input  logic [UART_DATA_W*N-1:0] req_data,
  input  logic [N-1:0]             req_last,
  output logic [N-1:0]             req_ack,
  output logic                     uart_tx_start,
  output logic [UART_DATA_W-1:0]   uart_tx_data,
  input  logic                     uart_tx_busy,
  output logic [OW-1:0]            arb_owner,
  output logic                     arb_locked
);

  arb_state_t             state_reg,  state_next;
  logic [UART_DATA_W-1:0] data_reg,   data_next;
  logic [OW-1:0]          owner_reg,  owner_next;
  logic                   locked_reg, locked_next;
  logic [OW-1:0]          ptr_reg,    ptr_next;
  logic [LOCK_CNT_W-1:0]  cnt_reg,    cnt_next;
  logic                   start_reg,  start_next;
  logic [N-1:0]           ack_reg,    ack_next;

  logic [UART_DATA_W-1:0] req_bytes [N];
  logic [N-1:0]           owner_hot;
  logic [N-1:0]           pick_hot;
  logic [N-1:0]           pick_req;
  logic                   pick_valid;
  logic [OW-1:0]          pick_idx;
  logic                   owner_req;
  logic                   can_grant;
  logic                   lock_to_hit;

  function automatic logic [OW-1:0] inc_mod(input logic [OW-1:0] i);
    return (i == OW'(N - 1)) ? '0 : i + OW'(1);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_req
      assign req_bytes[gi] = req_data[UART_DATA_W*gi +: UART_DATA_W];
      assign owner_hot[gi] = (owner_reg == OW'(gi));
      assign pick_hot[gi]  = (pick_idx == OW'(gi));
    end
  endgenerate

  // While locked only the owner's request reaches the picker, so it wins regardless of ptr
  assign pick_req  = locked_reg ? (req & owner_hot) : req;
  assign owner_req = |(req & owner_hot);

  uart_rr_pick #(
    .N  (N),
    .IW (OW)
  ) u_pick (
    .req   (pick_req),
    .ptr   (ptr_reg),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign can_grant   = (state_reg == ST_IDLE) && !uart_tx_busy && pick_valid;
  assign lock_to_hit = (state_reg == ST_IDLE) && locked_reg &&
                       (LOCK_TO != '0) && (cnt_reg == LOCK_TO);

  always_comb begin
    state_next  = state_reg;
    data_next   = data_reg;
    owner_next  = owner_reg;
    locked_next = locked_reg;
    ptr_next    = ptr_reg;
    cnt_next    = cnt_reg;
    start_next  = 1'b0;
    ack_next    = '0;

    case (state_reg)
      ST_IDLE: begin
        if (can_grant) begin
          data_next   = req_bytes[pick_idx];
          owner_next  = pick_idx;
          locked_next = ~req_last[pick_idx];
          ptr_next    = req_last[pick_idx] ? inc_mod(pick_idx) : pick_idx;
          cnt_next    = '0;
          start_next  = 1'b1;
          ack_next    = pick_hot;
          state_next  = ST_ISSUE;
        end else if (lock_to_hit) begin
          locked_next = 1'b0;
          ptr_next    = inc_mod(owner_reg);
          cnt_next    = '0;
        end else if (!locked_reg) begin
          cnt_next = '0;
        end else if (!owner_req) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_ISSUE: begin
        state_next = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (uart_tx_busy) begin
          state_next = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!uart_tx_busy) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge uart_clk) begin
    if (uart_rst) begin
      state_reg  <= ST_IDLE;
      data_reg   <= '0;
      owner_reg  <= '0;
      locked_reg <= 1'b0;
      ptr_reg    <= '0;
      cnt_reg    <= '0;
      start_reg  <= 1'b0;
      ack_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      data_reg   <= data_next;
      owner_reg  <= owner_next;
      locked_reg <= locked_next;
      ptr_reg    <= ptr_next;
      cnt_reg    <= cnt_next;
      start_reg  <= start_next;
      ack_reg    <= ack_next;
    end
  end

  assign req_ack       = ack_reg;
  assign uart_tx_start = start_reg;
  assign uart_tx_data  = data_reg;
  assign arb_owner     = owner_reg;
  assign arb_locked    = locked_reg;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: grant table plus timeout and reset-during-busy sequences.
module tb_uart_tx_arb;

  logic        uart_clk = 1'b0;
  logic        uart_rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ack;
  logic        uart_tx_start;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_busy;
  logic [1:0]  arb_owner;
  logic        arb_locked;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  uart_tx_arb #(
    .N       (4),
    .LOCK_TO (16'd20)
  ) dut (
    .uart_clk      (uart_clk),
    .uart_rst      (uart_rst),
    .req           (req),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ack       (req_ack),
    .uart_tx_start (uart_tx_start),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_busy  (uart_tx_busy),
    .arb_owner     (arb_owner),
    .arb_locked    (arb_locked)
  );

  always #5 uart_clk = ~uart_clk;

  always @(posedge uart_clk) cyc <= cyc + 1;

  // Behavioural transmitter: registers start, then stays busy for 10 cycles
  logic tx_busy_q = 1'b0;
  int   tx_left   = 0;
  always @(posedge uart_clk) begin
    if (uart_tx_start) begin
      tx_busy_q <= 1'b1;
      tx_left   <= 9;
    end else if (tx_left > 0) begin
      tx_left <= tx_left - 1;
    end else begin
      tx_busy_q <= 1'b0;
    end
  end
  assign uart_tx_busy = tx_busy_q;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  last;
    logic [31:0] data;
    logic [3:0]  exp_ack;
    logic [7:0]  exp_data;
    logic [1:0]  exp_owner;
    logic        exp_locked;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic [31:0] d);
    req      = r;
    req_last = l;
    req_data = d;
  endtask

  task automatic wait_start(output int sc);
    sc = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge uart_clk);
      if (uart_tx_start) begin
        sc = cyc;
        break;
      end
    end
    check("start_seen", 32'(sc >= 0), 32'd1);
  endtask

  int prev;
  int sc;
  int s_to;
  int lk_cyc;
  int early_starts;

  initial begin
    // rotation from pointer 0
    vecs[0]  = '{4'b1111, 4'b1111, 32'hA3A2A1A0, 4'b0001, 8'hA0, 2'd0, 1'b0};
    vecs[1]  = '{4'b1111, 4'b1111, 32'hA3A2A1B0, 4'b0010, 8'hA1, 2'd1, 1'b0};
    vecs[2]  = '{4'b1111, 4'b1111, 32'hA3A2B1B0, 4'b0100, 8'hA2, 2'd2, 1'b0};
    vecs[3]  = '{4'b1111, 4'b1111, 32'hA3B2B1B0, 4'b1000, 8'hA3, 2'd3, 1'b0};
    vecs[4]  = '{4'b1111, 4'b1111, 32'hB3B2B1B0, 4'b0001, 8'hB0, 2'd0, 1'b0};
    // single requester, 3-byte message
    vecs[5]  = '{4'b0001, 4'b0000, 32'h00000041, 4'b0001, 8'h41, 2'd0, 1'b1};
    vecs[6]  = '{4'b0001, 4'b0000, 32'h00000042, 4'b0001, 8'h42, 2'd0, 1'b1};
    vecs[7]  = '{4'b0001, 4'b0001, 32'h00000043, 4'b0001, 8'h43, 2'd0, 1'b0};
    // requester 2 locks a 2-byte message while 0 and 3 keep requesting
    vecs[8]  = '{4'b1101, 4'b1001, 32'hE3D000C0, 4'b0100, 8'hD0, 2'd2, 1'b1};
    vecs[9]  = '{4'b1101, 4'b1101, 32'hE3D100C0, 4'b0100, 8'hD1, 2'd2, 1'b0};
    vecs[10] = '{4'b1001, 4'b1001, 32'hE30000C0, 4'b1000, 8'hE3, 2'd3, 1'b0};
    vecs[11] = '{4'b1001, 4'b1001, 32'hE40000C0, 4'b0001, 8'hC0, 2'd0, 1'b0};

    uart_rst = 1'b1;
    drive(4'b0000, 4'b0000, 32'h0);
    repeat (3) @(negedge uart_clk);
    check("rst_start",  32'(uart_tx_start), 32'd0);
    check("rst_ack",    32'(req_ack),       32'd0);
    check("rst_data",   32'(uart_tx_data),  32'd0);
    check("rst_owner",  32'(arb_owner),     32'd0);
    check("rst_locked", 32'(arb_locked),    32'd0);
    uart_rst = 1'b0;
    @(negedge uart_clk);

    drive(vecs[0].req, vecs[0].last, vecs[0].data);
    prev = cyc;
    for (int i = 0; i < NV; i++) begin
      wait_start(sc);
      if (i == 0) check("latency", 32'(sc - prev), 32'd1);
      else        check("byte_gap", 32'(sc - prev), 32'd13);
      prev = sc;
      check("ack",    32'(req_ack),      32'(vecs[i].exp_ack));
      check("data",   32'(uart_tx_data), 32'(vecs[i].exp_data));
      check("owner",  32'(arb_owner),    32'(vecs[i].exp_owner));
      check("locked", 32'(arb_locked),   32'(vecs[i].exp_locked));
      $display("vec %0d: cycle %0d ack=%b data=%h owner=%0d locked=%0d",
               i, sc, req_ack, uart_tx_data, arb_owner, arb_locked);
      if (i + 1 < NV) drive(vecs[i+1].req, vecs[i+1].last, vecs[i+1].data);
      else            drive(4'b0010, 4'b0000, 32'h0000F100);
      @(negedge uart_clk);
      check("start_width", 32'(uart_tx_start), 32'd0);
      check("ack_width",   32'(req_ack),       32'd0);
    end

    // lock timeout: requester 1 stalls after a non-last byte, requester 0 waits
    wait_start(s_to);
    check("to_owner",  32'(arb_owner),    32'd1);
    check("to_locked", 32'(arb_locked),   32'd1);
    check("to_data",   32'(uart_tx_data), 32'hF1);
    $display("timeout lock: cycle %0d owner=%0d locked=%0d", s_to, arb_owner, arb_locked);
    drive(4'b0001, 4'b0001, 32'h00000055);
    lk_cyc = -1;
    early_starts = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge uart_clk);
      if (uart_tx_start) early_starts++;
      if (!arb_locked) begin
        lk_cyc = cyc;
        break;
      end
    end
    check("to_release_cycle", 32'(lk_cyc - s_to), 32'd33);
    check("to_no_early_start", 32'(early_starts), 32'd0);
    wait_start(sc);
    check("to_grant_cycle", 32'(sc - lk_cyc), 32'd1);
    check("to_grant_owner", 32'(arb_owner),    32'd0);
    check("to_grant_data",  32'(uart_tx_data), 32'h55);
    $display("timeout release: cycle %0d, regrant cycle %0d owner=%0d data=%h",
             lk_cyc, sc, arb_owner, uart_tx_data);

    // reset while the transmitter is busy
    drive(4'b0001, 4'b0001, 32'h00000077);
    wait_start(prev);
    check("rb_data", 32'(uart_tx_data), 32'h77);
    repeat (3) @(negedge uart_clk);
    uart_rst = 1'b1;
    @(negedge uart_clk);
    check("rb_start",  32'(uart_tx_start), 32'd0);
    check("rb_ack",    32'(req_ack),       32'd0);
    check("rb_data0",  32'(uart_tx_data),  32'd0);
    check("rb_owner",  32'(arb_owner),     32'd0);
    check("rb_locked", 32'(arb_locked),    32'd0);
    check("rb_busy",   32'(uart_tx_busy),  32'd1);
    uart_rst = 1'b0;
    drive(4'b0001, 4'b0001, 32'h00000078);
    wait_start(sc);
    check("rb_first_start", 32'(sc - prev), 32'd12);
    check("rb_regrant_data", 32'(uart_tx_data), 32'h78);
    check("rb_regrant_ack",  32'(req_ack),      32'b0001);
    $display("reset during busy: byte 77 at cycle %0d, byte 78 at cycle %0d", prev, sc);
    drive(4'b0000, 4'b0000, 32'h0);
    repeat (15) @(negedge uart_clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter that shares one UART transmitter among N byte-stream requesters. It sequences the transmitter's `uart_tx_start`/`uart_tx_busy` handshake and forwards the granted byte. Its packet lock keeps multi-byte messages from interleaving, and a lock timeout recovers from a requester that stalls mid-message. It sits between the firmware/debug byte sources and `uart_tx`.

## Interface
- `N`, default 4: number of requesters, 2..16.
- `LOCK_TO`, default 16'hFFFF: idle-clock limit while locked. 0 disables the timeout.
- `uart_clk`  in  1  clock.
- `uart_rst`  in  1  reset, synchronous, active-high.
- `req`  in  N  per-requester byte valid. Held until the matching `req_ack`.
- `req_data`  in  8*N  flattened bytes; requester i at [8i+7:8i].
- `req_last`  in  N  byte ends the requester's message and releases the lock.
- `req_ack`  out  N  one-hot, one-cycle pulse: byte taken.
- `uart_tx_start`  out  1  one-cycle start pulse to the transmitter.
- `uart_tx_data`  out  8  byte to the transmitter. Stable from start until the next grant.
- `uart_tx_busy`  in  1  transmitter busy.
- `arb_owner`  out  max(1,clog2(N))  last granted requester.
- `arb_locked`  out  1  lock held by `arb_owner`.

## Operation
- **Reset values:** state IDLE; all outputs 0; rr pointer 0; timeout counter 0.
- **IDLE.** The block grants only when `uart_tx_busy`==0.
  - When unlocked: search `req` starting at the pointer and wrapping modulo N; the first set bit i wins.
  - When locked: only `req[arb_owner]` is eligible; all other requests wait.
  - On a grant:
    - latch `req_data[i]` into `uart_tx_data`;
    - set `arb_owner`=i;
    - set `arb_locked`=~`req_last[i]`;
    - set pointer = `req_last[i]` ? (i+1) mod N : i;
    - go to ISSUE.
- **ISSUE:** `uart_tx_start`=1 and `req_ack[arb_owner]`=1 for this cycle only; go to WAIT_BUSY.
- **WAIT_BUSY:** go to WAIT_DONE when `uart_tx_busy`=1; otherwise stay.
- **WAIT_DONE:** go to IDLE when `uart_tx_busy`=0.
- **Timeout counter:** 16-bit.
  - Increments each IDLE cycle with `arb_locked`=1 and `req[arb_owner]`=0.
  - Clears on every grant and whenever unlocked.
  - When it equals `LOCK_TO` (and `LOCK_TO`≠0):
    - clear `arb_locked`;
    - set pointer = (`arb_owner`+1) mod N;
    - clear the counter;
    - no grant that cycle.
- **Simultaneous events:**
  - A timeout and an owner request in the same cycle: the grant wins and the counter clears.
  - Requests arriving outside IDLE are ignored until IDLE.
- **Reset mid-frame:** all registers return to reset values. If the transmitter is still busy, IDLE holds off granting until busy falls. No partial byte is re-sent.

## Timing
- `req` sampled in IDLE at cycle 0 → `uart_tx_start` and `req_ack` high in cycle 1.
- `uart_tx_busy` is expected high in cycle 2 (the transmitter registers start).
- Busy falls in cycle m → IDLE in m+1, next sample in m+1, next start in m+2.
  - Inter-byte overhead: 2 clocks beyond the transmitter's frame time.
- A requester must hold `req`/`req_data`/`req_last` stable until it sees `req_ack`. It may change them in the ack cycle.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Shared package `uart_pkg`:
  - state encodings (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE);
  - `UART_DATA_W`=8;
  - lock-timeout counter width (16).
- Sub-module `uart_rr_pick`: combinational rotate-priority picker.
  - Inputs: N-bit request vector and pointer.
  - Outputs: valid, winner index.
  - Reusable for any future UART RX-side dispatcher.
- Top level holds the FSM, data/owner/lock/pointer registers and the timeout counter.

## Test plan
- **Single requester, 3 bytes.** `req[0]` with 8'h41, 8'h42, 8'h43 (last on 8'h43); behavioural transmitter with 10-cycle busy → three starts, each exactly one cycle; `uart_tx_data` matches each byte; `arb_locked` clears after 8'h43.
- **Rotation.** All 4 requesters request single bytes (last=1) with `uart_tx_busy` idle → grant order 0,1,2,3,0; each `req_ack` is a one-cycle one-hot pulse.
- **Lock.** Requester 2 sends a 2-byte message (last=0 then last=1) while requesters 0 and 3 request continuously → both requester-2 bytes go back-to-back; then requester 3 is granted, then 0.
- **Lock timeout.** `LOCK_TO`=20; requester 1 sends last=0 then drops `req`; requester 0 requests → `arb_locked` clears exactly 20 idle cycles after entry to IDLE; requester 0 is granted on the next cycle.
- **Busy handshake and reset.** `uart_rst` asserted while `uart_tx_busy`=1 → outputs 0 the next cycle; no `uart_tx_start` until busy falls; the first start comes one cycle after the first IDLE sample with busy=0.
